// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage pipeline stall/flush scheduler.
//   REG_IDX_W    : architectural register index width (shared with forwarding)
//   ctrl_state_e : scheduler states (RUN, MEM_WAIT)
//   stage_ctrl_t : grouped enable/flush bits for the PC and pipeline registers
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // Everything advances, nothing squashed.
  localparam stage_ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
    id_ex_en: 1'b1, id_ex_flush: 1'b0,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_flush: 1'b0
  };

  // Whole pipe holds; WB receives a bubble so a stalled MEM result is not
  // retired twice.
  localparam stage_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b0,
    ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_flush: 1'b1
  };

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector.
//   id_rs1/id_rs2         : source indices of the instruction in ID
//   id_use_rs1/id_use_rs2 : ID instruction actually reads that source
//   ex_mem_read           : instruction in EX is a load
//   ex_rd                 : destination of the instruction in EX
//   hazard                : ID needs a value the load in EX has not produced
// ---------------------------------------------------------------------------
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic [REG_IDX_W-1:0] src_idx [2];
  logic [1:0]           src_use;
  logic [1:0]           src_match;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;
  assign src_use    = {id_use_rs2, id_use_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_use[gi] && (src_idx[gi] == ex_rd);
    end
  endgenerate

  // x0 is hardwired zero, so a load "to x0" never creates a dependency.
  assign hazard = ex_mem_read && (ex_rd != '0) && (|src_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline.
// Inputs : clk, rst_n (async, active low), ID source fields, EX load/rd,
//          ex_redirect, dmem_req/dmem_ready handshake.
// Outputs: pc_en and the en/flush pins of every pipeline register
//          (combinational), mem_err (watchdog pulse), stall_cnt and
//          flush_cnt performance counters.
// Priority: memory freeze > redirect flush > load-use bubble > normal.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_redirect,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 mem_wb_flush,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;

  ctrl_state_e          state_reg, state_next;
  logic [TIMEOUT_W-1:0] wd_reg, wd_next;
  stage_ctrl_t          ctrl;
  logic                 freeze;
  logic                 redirect_taken;
  logic                 hazard;

  load_use_detect u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  // Next state, watchdog and per-stage control.
  always_comb begin
    state_next     = state_reg;
    wd_next        = '0;
    freeze         = 1'b0;
    mem_err        = 1'b0;
    redirect_taken = 1'b0;
    ctrl           = CTRL_NORMAL;

    case (state_reg)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // Only dmem_ready or the watchdog release the freeze; dmem_req is
        // ignored here because the frozen MEM stage is assumed to hold it.
        if (dmem_ready) begin
          state_next = RUN;
        end else if (wd_reg == WD_LIMIT) begin
          // Abort: the release cycle advances the pipe like a normal RUN.
          state_next = RUN;
          mem_err    = 1'b1;
        end else begin
          freeze  = 1'b1;
          wd_next = (wd_reg == WD_MAX) ? wd_reg : wd_reg + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redirect) begin
      // Squashes the wrong-path IF and ID instructions; this also removes
      // any load-use dependent sitting in ID, so no stall is needed.
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      redirect_taken   = 1'b1;
    end else if (hazard) begin
      // Hold PC and IF/ID one cycle, push a bubble into EX; afterwards the
      // load sits in MEM and forwarding covers the dependency.
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      wd_reg    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      if (!ctrl.pc_en) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_taken) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic       dmem_req, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_en, mem_wb_flush, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_wait;
  int          m_waited;
  int unsigned m_stall, m_flush;
  bit          e_pc, e_redir, e_frz, e_timeout;

  pipeline_ctrl #(.TIMEOUT_W(8), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; ex_redirect = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
  endtask

  // Evaluate the model for the current inputs and compare at the negedge.
  task automatic cyc_eval();
    bit hz;
    logic [8:0] exp_v, act_v;
    @(negedge clk);
    hz = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_frz = 0; e_timeout = 0;
    if (!m_wait) e_frz = dmem_req && !dmem_ready;
    else if (!dmem_ready) begin
      if (m_waited == TO - 1) e_timeout = 1;
      else e_frz = 1;
    end
    e_redir = !e_frz && ex_redirect;
    if (e_frz)        exp_v = 9'b0_0_0_0_0_0_0_1_0;
    else if (e_redir) exp_v = 9'b1_1_1_1_1_1_1_0_0;
    else if (hz)      exp_v = 9'b0_0_0_1_1_1_1_0_0;
    else              exp_v = 9'b1_1_0_1_0_1_1_0_0;
    exp_v[0] = e_timeout;
    e_pc = exp_v[8];
    act_v = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_en, mem_wb_flush, mem_err};
    chk("ctrl_vec", 32'(act_v), 32'(exp_v));
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    $display("cyc t=%0t req=%b rdy=%b redir=%b ld=%b rd=%0d ctrl=%b st=%0d fl=%0d",
             $time, dmem_req, dmem_ready, ex_redirect, ex_mem_read, ex_rd,
             act_v, stall_cnt, flush_cnt);
  endtask

  // Clock edge: advance the model.
  task automatic cyc_adv();
    @(posedge clk);
    if (!e_pc) m_stall++;
    if (e_redir) m_flush++;
    if (!m_wait) begin
      if (e_frz) begin m_wait = 1; m_waited = 0; end
    end else if (dmem_ready || e_timeout) begin
      m_wait = 0; m_waited = 0;
    end else if (m_waited < 255) begin
      m_waited++;
    end
    #1;
  endtask

  task automatic randomize_inputs();
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    id_use_rs1  = 1'($urandom_range(0, 1));
    id_use_rs2  = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 99) < 50);
    ex_redirect = ($urandom_range(0, 99) < 15);
    dmem_req    = ($urandom_range(0, 99) < 40);
    dmem_ready  = ($urandom_range(0, 99) < 35);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    cyc_eval();
    chk("reset_pc_en", 32'(pc_en), 1);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    chk("reset_mem_err", 32'(mem_err), 0);
    cyc_adv();

    // Load-use: lw x5 in EX, add reading x5 in ID
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cyc_eval();
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_ex_mem_en", 32'(ex_mem_en), 1);
    cyc_adv();
    idle();
    cyc_eval();
    chk("lu_next_pc_en", 32'(pc_en), 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    cyc_adv();

    // x0 destination never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    cyc_eval();
    chk("x0_pc_en", 32'(pc_en), 1);
    chk("x0_id_ex_flush", 32'(id_ex_flush), 0);
    cyc_adv();

    // Redirect together with load-use
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_redirect = 1;
    cyc_eval();
    chk("rd_if_id_flush", 32'(if_id_flush), 1);
    chk("rd_id_ex_flush", 32'(id_ex_flush), 1);
    chk("rd_pc_en", 32'(pc_en), 1);
    cyc_adv();
    idle();
    cyc_eval();
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt", stall_cnt, 1);
    cyc_adv();

    // Memory wait: ready low 3 cycles, then ready
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc_eval();
      chk("mw_pc_en", 32'(pc_en), 0);
      chk("mw_ex_mem_en", 32'(ex_mem_en), 0);
      chk("mw_mem_wb_flush", 32'(mem_wb_flush), 1);
      cyc_adv();
    end
    dmem_ready = 1;
    cyc_eval();
    chk("mw_release_pc_en", 32'(pc_en), 1);
    chk("mw_release_mem_wb_en", 32'(mem_wb_en), 1);
    cyc_adv();
    idle();
    cyc_eval();
    chk("mw_stall_cnt", stall_cnt, 4);
    cyc_adv();

    // Watchdog: ready never rises
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cyc_eval();
      chk("wd_frozen_pc_en", 32'(pc_en), 0);
      chk("wd_no_err", 32'(mem_err), 0);
      cyc_adv();
    end
    cyc_eval();
    chk("wd_mem_err", 32'(mem_err), 1);
    chk("wd_release_pc_en", 32'(pc_en), 1);
    cyc_adv();
    dmem_req = 0;
    cyc_eval();
    chk("wd_err_cleared", 32'(mem_err), 0);
    chk("wd_stall_cnt", stall_cnt, 8);
    cyc_adv();

    // Randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      cyc_eval();
      cyc_adv();
    end

    // Async reset while in MEM_WAIT
    idle();
    dmem_ready = 1;
    cyc_eval(); cyc_adv();
    dmem_req = 1; dmem_ready = 0;
    cyc_eval(); cyc_adv();
    cyc_eval(); cyc_adv();
    #2 rst_n = 0;
    #1;
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_flush_cnt", flush_cnt, 0);
    chk("ar_mem_err", 32'(mem_err), 0);
    dmem_req = 0;
    #1;
    chk("ar_pc_en", 32'(pc_en), 1);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cyc_eval();
    chk("ar_after_pc_en", 32'(pc_en), 1);
    cyc_adv();
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      cyc_eval();
      cyc_adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable and the enable/flush pins of every pipeline register.
- Detects load-use hazards that forwarding cannot cover and applies branch/jump redirect flushes.
- Freezes the whole pipe while the data-memory port has not accepted a transaction; sits beside the forwarding unit, whose mux selects stay valid because frozen registers hold their contents.

Parameters:
- TIMEOUT_W, 8, width of the memory-wait watchdog counter.
- MEM_TIMEOUT, 200, wait cycles before the watchdog aborts a memory wait.
- CNT_W, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  rd of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch/jump (PC redirect).
- dmem_req  in  1  MEM stage presents a load/store this cycle.
- dmem_ready  in  1  data memory accepts/completes the request this cycle.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register bubble insert.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX register bubble insert.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- mem_wb_flush  out  1  MEM/WB register bubble insert.
- mem_err  out  1  one-cycle pulse when the watchdog fires.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  count of redirect flushes.

Behaviour:
- States: RUN, MEM_WAIT. Reset state is RUN, the watchdog counter is 0, both perf counters are 0, and mem_err is 0.
- All enable and flush outputs are combinational from state plus inputs.
- In reset, the enables evaluate to 1 and the flushes to 0 (RUN, no hazard); holding them is harmless because the pipeline registers reset themselves.
- Memory freeze (highest priority):
  - Active when (state==RUN and dmem_req and !dmem_ready) or state==MEM_WAIT with dmem_ready still low.
  - During the freeze: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en = 0; mem_wb_flush = 1, so WB sees a bubble; all other flushes = 0.
- Transitions:
  - RUN→MEM_WAIT on dmem_req && !dmem_ready.
  - MEM_WAIT→RUN on dmem_ready, or when the watchdog reaches MEM_TIMEOUT-1.
  - The release cycle behaves as RUN, so the pipe advances that cycle.
  - dmem_req is assumed held by the frozen MEM stage; dropping it in MEM_WAIT has no effect (only dmem_ready releases).
- Watchdog:
  - Increments each MEM_WAIT cycle and clears on exit.
  - On timeout: mem_err=1 for exactly one cycle, state returns to RUN, and the pipe advances.
  - The counter saturates and never wraps.
- Redirect (second priority, RUN only):
  - When ex_redirect=1: if_id_flush=1 and id_ex_flush=1; pc_en=1, if_id_en=1, id_ex_en=1.
  - flush_cnt increments by 1.
  - Redirect outranks load-use, because the dependent ID instruction is squashed.
- Load-use (third priority, RUN only, no redirect):
  - Hazard when ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; downstream enables stay 1.
  - Produces exactly one bubble. The next cycle the load is in MEM and forwarding from MEM/WB covers the dependency.
- Normal: all enables 1, all flushes 0.
- stall_cnt increments on every cycle with pc_en==0 outside reset.
- Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-MEM_WAIT: immediately returns to RUN, clears the watchdog, and suppresses mem_err.

Decomposition:
- Shared package holds:
  - ctrl_state_e {RUN, MEM_WAIT};
  - a packed struct stage_ctrl_t grouping the en/flush bits;
  - the register-index width constant already used by the forwarding unit.
- One natural sub-module: load_use_detect, purely combinational, producing the hazard bit from the ID/EX fields.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5); ID add reading id_rs1=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt +1; the next cycle runs normally.
- x0 case: ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall; all enables 1.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt +1; stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles -> 3 frozen cycles with all enables 0 and mem_wb_flush=1; normal on the ready cycle; stall_cnt +3.
- Watchdog: MEM_TIMEOUT=4, dmem_ready never rises -> mem_err pulses on the 4th wait cycle, state returns to RUN, and the pipe advances.
- Async reset: drop rst_n in MEM_WAIT between clock edges -> state RUN, counters 0, mem_err 0 immediately, without waiting for a clock.
